// File: rtl/qam_pkg.sv
// Shared types and defaults for the QAM transmit sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package qam_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int         DEFAULT_BIT_PERIOD = 16;
    localparam logic [7:0] DEFAULT_IDLE_BYTE  = 8'h00;

    // Bit timer width; a period of 1 would give a zero-width counter.
    function automatic int timer_width(input int period);
        return (period > 1) ? $clog2(period) : 1;
    endfunction

endpackage

// File: rtl/qam_bit_timer.sv
// Bit period timer: counts 0..BIT_PERIOD-1 while running and flags the last cycle.
// Latency: tick asserts BIT_PERIOD-1 cycles after the first running cycle following a clear.
// Backpressure: none; clear wins over run.
module qam_bit_timer
    import qam_pkg::*;
#(
    parameter int BIT_PERIOD = DEFAULT_BIT_PERIOD
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic tick
);

    localparam int              TW   = timer_width(BIT_PERIOD);
    localparam logic [TW-1:0]   LAST = TW'(BIT_PERIOD - 1);

    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;

    assign tick = run && (timer_q == LAST);

    // Next timer value: wrap on tick so non-power-of-two periods work.
    always_comb begin
        timer_d = timer_q;
        if (clear) begin
            timer_d = '0;
        end else if (run) begin
            timer_d = tick ? '0 : timer_q + 1'b1;
        end
    end

    // Timer register.
    always_ff @(posedge clock) begin
        if (reset) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

endmodule

// File: rtl/qam_tx_sequencer.sv
// Serialises bytes MSB first at BIT_PERIOD cycles per bit, with per-bit strobe and 2-bit symbols.
// Latency: first bit drives the cycle after the accepting edge; first strobe BIT_PERIOD cycles after acceptance.
// Backpressure: byte_ready only in IDLE or on the last strobe of a byte; underrun inserts IDLE_BYTE.
module qam_tx_sequencer
    import qam_pkg::*;
#(
    parameter int         BIT_PERIOD = DEFAULT_BIT_PERIOD,
    parameter logic [7:0] IDLE_BYTE  = DEFAULT_IDLE_BYTE
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       adat_be_S,
    output logic       data_change,
    output logic       symbol_valid,
    output logic [1:0] symbol,
    output logic       busy,
    output logic       underrun
);

    state_t     state_q, state_d;
    logic [7:0] shreg_q, shreg_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       prev_bit_q, prev_bit_d;
    logic [1:0] symbol_q, symbol_d;
    logic       symbol_valid_q, symbol_valid_d;
    logic       underrun_q, underrun_d;

    logic       shifting;
    logic       timer_clear;
    logic       tick;
    logic       boundary;
    logic       xfer;

    assign shifting    = (state_q == SHIFT);
    // Holding the timer cleared in IDLE makes the first SHIFT cycle start at zero.
    assign timer_clear = (state_q == IDLE);

    qam_bit_timer #(
        .BIT_PERIOD (BIT_PERIOD)
    ) u_bit_timer (
        .clock (clock),
        .reset (reset),
        .clear (timer_clear),
        .run   (shifting),
        .tick  (tick)
    );

    assign boundary     = tick && (bit_cnt_q == 3'd7);
    // Bytes are only taken at a byte boundary so symbol framing never slips.
    assign byte_ready   = !reset && enable && ((state_q == IDLE) || boundary);
    assign xfer         = byte_valid && byte_ready;

    assign adat_be_S    = shifting && shreg_q[7];
    assign data_change  = tick;
    assign busy         = shifting;
    assign symbol       = symbol_q;
    assign symbol_valid = symbol_valid_q;
    assign underrun     = underrun_q;

    // Next-state: load, shift, symbol pairing and the byte-boundary decision.
    always_comb begin
        state_d        = state_q;
        shreg_d        = shreg_q;
        bit_cnt_d      = bit_cnt_q;
        prev_bit_d     = prev_bit_q;
        symbol_d       = symbol_q;
        symbol_valid_d = 1'b0;
        underrun_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    state_d   = SHIFT;
                    shreg_d   = byte_data;
                    bit_cnt_d = 3'd0;
                end
            end
            SHIFT: begin
                if (tick) begin
                    prev_bit_d = shreg_q[7];
                    // Odd bit index closes a symbol: {older, newer}.
                    if (bit_cnt_q[0]) begin
                        symbol_d       = {prev_bit_q, shreg_q[7]};
                        symbol_valid_d = 1'b1;
                    end
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    shreg_d   = {shreg_q[6:0], 1'b0};
                    if (boundary) begin
                        if (xfer) begin
                            shreg_d = byte_data;
                        end else if (enable) begin
                            shreg_d    = IDLE_BYTE;
                            underrun_d = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any partial byte.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            shreg_q        <= 8'h00;
            bit_cnt_q      <= 3'd0;
            prev_bit_q     <= 1'b0;
            symbol_q       <= 2'b00;
            symbol_valid_q <= 1'b0;
            underrun_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            shreg_q        <= shreg_d;
            bit_cnt_q      <= bit_cnt_d;
            prev_bit_q     <= prev_bit_d;
            symbol_q       <= symbol_d;
            symbol_valid_q <= symbol_valid_d;
            underrun_q     <= underrun_d;
        end
    end

endmodule

// File: tb/tb_qam_tx_sequencer.sv
// Directed bench for qam_tx_sequencer with BIT_PERIOD=4 and IDLE_BYTE=8'h00.
// Cycle k counts edges after the accepting cycle T; inputs change 1 unit after each edge.
// Outputs are sampled 2 units after each edge.
module tb_qam_tx_sequencer;

    localparam int BP = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_ready;
    logic       adat_be_S;
    logic       data_change;
    logic       symbol_valid;
    logic [1:0] symbol;
    logic       busy;
    logic       underrun;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    qam_tx_sequencer #(
        .BIT_PERIOD (BP),
        .IDLE_BYTE  (8'h00)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .byte_data    (byte_data),
        .byte_valid   (byte_valid),
        .byte_ready   (byte_ready),
        .adat_be_S    (adat_be_S),
        .data_change  (data_change),
        .symbol_valid (symbol_valid),
        .symbol       (symbol),
        .busy         (busy),
        .underrun     (underrun)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check_cycle(input string t, input int k, input logic e_dc, input logic e_adat,
                               input logic e_busy, input logic e_rdy, input logic e_svld,
                               input logic e_und);
        check($sformatf("%s dc@%0d", t, k),   8'(data_change),  8'(e_dc));
        check($sformatf("%s adat@%0d", t, k), 8'(adat_be_S),    8'(e_adat));
        check($sformatf("%s busy@%0d", t, k), 8'(busy),         8'(e_busy));
        check($sformatf("%s rdy@%0d", t, k),  8'(byte_ready),   8'(e_rdy));
        check($sformatf("%s svld@%0d", t, k), 8'(symbol_valid), 8'(e_svld));
        check($sformatf("%s und@%0d", t, k),  8'(underrun),     8'(e_und));
    endtask

    // One byte, enable dropped right after acceptance so it goes back to IDLE.
    task automatic run_single(input string t, input logic [7:0] b);
        int   j;
        logic sv;
        enable     = 1'b1;
        byte_valid = 1'b1;
        byte_data  = b;
        settle();
        check({t, " rdy_idle"}, 8'(byte_ready), 8'd1);
        for (int k = 1; k <= 34; k++) begin
            step();
            enable     = 1'b0;
            byte_valid = 1'b0;
            byte_data  = 8'h00;
            settle();
            sv = (k >= 9) && (k <= 33) && (k % 8 == 1);
            check_cycle(t, k, (k <= 32) && (k % 4 == 0),
                        (k <= 32) ? b[7 - (k - 1) / 4] : 1'b0,
                        k <= 32, 1'b0, sv, 1'b0);
            if (sv) begin
                j = (k - 9) / 8;
                check($sformatf("%s sym@%0d", t, k), 8'(symbol), 8'(b[7 - 2 * j -: 2]));
            end
        end
    endtask

    initial begin
        logic [7:0] cur;
        logic [7:0] sb;
        logic       sv;
        int         j;

        reset      = 1'b1;
        enable     = 1'b1;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        step();
        step();
        settle();
        check("rst rdy",  8'(byte_ready),   8'd0);
        check("rst adat", 8'(adat_be_S),    8'd0);
        check("rst dc",   8'(data_change),  8'd0);
        check("rst svld", 8'(symbol_valid), 8'd0);
        check("rst sym",  8'(symbol),       8'd0);
        check("rst busy", 8'(busy),         8'd0);
        check("rst und",  8'(underrun),     8'd0);
        reset  = 1'b0;
        enable = 1'b0;
        step();

        // Single byte B4: bits 1,0,1,1,0,1,0,0; symbols 10,11,01,00.
        run_single("t1", 8'hB4);
        step();

        // A5 then 3C back to back, byte_valid held with 3C during the whole first byte.
        enable     = 1'b1;
        byte_valid = 1'b1;
        byte_data  = 8'hA5;
        settle();
        check("t2 rdy_idle", 8'(byte_ready), 8'd1);
        for (int k = 1; k <= 66; k++) begin
            step();
            enable     = (k <= 32);
            byte_valid = (k <= 32);
            byte_data  = (k <= 32) ? 8'h3C : 8'h00;
            settle();
            cur = (k <= 32) ? 8'hA5 : 8'h3C;
            sv  = (k >= 9) && (k <= 65) && (k % 8 == 1);
            check_cycle("t2", k, (k <= 64) && (k % 4 == 0),
                        (k <= 64) ? cur[7 - ((k - 1) % 32) / 4] : 1'b0,
                        k <= 64, k == 32, sv, 1'b0);
            if (sv) begin
                sb = (k <= 33) ? 8'hA5 : 8'h3C;
                j  = ((k - 9) / 8) % 4;
                check($sformatf("t2 sym@%0d", k), 8'(symbol), 8'(sb[7 - 2 * j -: 2]));
            end
        end

        // 5A then underrun for two byte slots; enable falls after the second fill starts.
        enable     = 1'b1;
        byte_valid = 1'b1;
        byte_data  = 8'h5A;
        settle();
        check("t3 rdy_idle", 8'(byte_ready), 8'd1);
        for (int k = 1; k <= 100; k++) begin
            step();
            enable     = (k <= 64);
            byte_valid = 1'b0;
            byte_data  = 8'h00;
            settle();
            cur = (k <= 32) ? 8'h5A : 8'h00;
            sv  = (k >= 9) && (k <= 97) && (k % 8 == 1);
            check_cycle("t3", k, (k <= 96) && (k % 4 == 0),
                        (k <= 96) ? cur[7 - ((k - 1) % 32) / 4] : 1'b0,
                        k <= 96, (k == 32) || (k == 64), sv, (k == 33) || (k == 65));
            if (sv) begin
                sb = (k <= 33) ? 8'h5A : 8'h00;
                j  = ((k - 9) / 8) % 4;
                check($sformatf("t3 sym@%0d", k), 8'(symbol), 8'(sb[7 - 2 * j -: 2]));
            end
        end

        // C3 with enable dropped after the 3rd strobe: byte still completes.
        enable     = 1'b1;
        byte_valid = 1'b1;
        byte_data  = 8'hC3;
        settle();
        check("t4 rdy_idle", 8'(byte_ready), 8'd1);
        for (int k = 1; k <= 40; k++) begin
            step();
            enable     = (k <= 12);
            byte_valid = 1'b0;
            byte_data  = 8'h00;
            settle();
            sv = (k >= 9) && (k <= 33) && (k % 8 == 1);
            check_cycle("t4", k, (k <= 32) && (k % 4 == 0),
                        (k <= 32) ? cur_bit(8'hC3, k) : 1'b0,
                        k <= 32, 1'b0, sv, 1'b0);
        end

        // 96 interrupted by reset after the 5th strobe, then 6C from scratch.
        enable     = 1'b1;
        byte_valid = 1'b1;
        byte_data  = 8'h96;
        settle();
        check("t5 rdy_idle", 8'(byte_ready), 8'd1);
        for (int k = 1; k <= 22; k++) begin
            step();
            enable     = (k <= 21);
            byte_valid = 1'b0;
            reset      = (k == 21);
            settle();
            if (k <= 20) begin
                sv = (k == 9) || (k == 17);
                check_cycle("t5", k, (k % 4 == 0), cur_bit(8'h96, k), 1'b1, 1'b0, sv, 1'b0);
                if (k == 17) begin
                    check("t5 sym@17", 8'(symbol), 8'h01);
                end
            end else if (k == 21) begin
                check("t5 rdy_in_reset", 8'(byte_ready), 8'd0);
            end else begin
                check_cycle("t5 post_rst", k, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                check("t5 post_rst sym", 8'(symbol), 8'h00);
            end
        end
        run_single("t5b", 8'h6C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Bit sent during cycle k (1..32) of a byte started at T.
    function automatic logic cur_bit(input logic [7:0] b, input int k);
        return b[7 - (k - 1) / 4];
    endfunction

endmodule
